// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Shared definitions for the clearable RAM (ram_clr) and its storage core
// (ram_core).
//   state_e  : controller state, CLEAR (hardware sweep) or IDLE (accepting
//              accesses).
//   addr_w_f : address width helper, ceil(log2(depth)) with a floor of 1 so
//              a one-word memory still has a real address port.
// ---------------------------------------------------------------------------
package ram_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_e;

   // clog2 that never returns 0 (depth 1 and 2 both give a 1-bit address)
   function automatic int addr_w_f(input int depth);
      if (depth > 2) begin
         return $clog2(depth);
      end else begin
         return 1;
      end
   endfunction

endpackage : ram_pkg

// File: rtl/ram_core.sv
// ---------------------------------------------------------------------------
// ram_core
// Plain single-port storage array with a synchronous write and a registered
// synchronous read. It has no reset at all so synthesis can map it onto
// block RAM; clearing is done by the parent writing every word.
// Ports:
//   clk      in            rising-edge clock
//   we_i     in            write enable (address must already be in range)
//   re_i     in            read enable  (address must already be in range)
//   addr_i   in  ADDR_W    shared read/write address
//   wdata_i  in  WIDTH     write data
//   rdata_o  out WIDTH     registered read data, updated only when re_i=1
// WRITE_THROUGH selects what a same-cycle read+write returns:
//   0 -> contents before the write, 1 -> wdata_i.
// ---------------------------------------------------------------------------
module ram_core import ram_pkg::*; #(
   parameter int WIDTH         = 8,
   parameter int DEPTH         = 8,
   parameter int ADDR_W        = addr_w_f(DEPTH),
   parameter int WRITE_THROUGH = 0
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Write port: store wdata_i at addr_i.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   // Read port: the array read sees pre-edge contents, so old data is the
   // natural result; write-through bypasses with the incoming word instead.
   always_ff @(posedge clk) begin
      if (re_i) begin
         if ((WRITE_THROUGH != 0) && we_i) begin
            rdata_q <= wdata_i;
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule : ram_core

// File: rtl/ram_clr.sv
// ---------------------------------------------------------------------------
// ram_clr
// Parametrised single-port synchronous RAM with a hardware clear sweep.
// After reset (and on every clr_req) the controller walks clr_ptr from 0 to
// DEPTH-1 writing INIT_VAL, one word per cycle, then goes IDLE and accepts
// accesses. The array is never reset directly.
// Ports:
//   clk         in            rising-edge clock
//   reset       in            asynchronous active-low reset
//   clr_req     in            start a full clear sweep (sampled while ready)
//   ready       out           1 while IDLE, accesses accepted
//   write_en    in            write strobe
//   read_en     in            read strobe
//   addr        in  ADDR_W    word address (shared by read and write)
//   write_data  in  WIDTH     write data
//   read_data   out WIDTH     registered read data, holds between reads
//   read_valid  out           one-cycle pulse, read_data just updated
//   addr_err    out           one-cycle pulse, accepted access had addr>=DEPTH
// ---------------------------------------------------------------------------
module ram_clr import ram_pkg::*; #(
   parameter int               WIDTH         = 8,
   parameter int               DEPTH         = 8,
   parameter int               ADDR_W        = addr_w_f(DEPTH),
   parameter logic [WIDTH-1:0] INIT_VAL      = {WIDTH{1'b0}},
   parameter int               WRITE_THROUGH = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_req,
   output logic              ready,
   input  logic              write_en,
   input  logic              read_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  write_data,
   output logic [WIDTH-1:0]  read_data,
   output logic              read_valid,
   output logic              addr_err
);

   // One extra bit so DEPTH itself is representable when DEPTH==2**ADDR_W.
   localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   state_e            state_q,      state_d;
   logic [ADDR_W-1:0] clr_ptr_q,    clr_ptr_d;
   logic              read_valid_q, read_valid_d;
   logic              addr_err_q,   addr_err_d;
   // Set by the first completed read; masks the unreset core output so
   // read_data reads as zero until real data has been fetched.
   logic              rd_seen_q,    rd_seen_d;

   logic              in_range_s;
   logic              mem_we_s;
   logic              mem_re_s;
   logic [ADDR_W-1:0] mem_addr_s;
   logic [WIDTH-1:0]  mem_wdata_s;
   logic [WIDTH-1:0]  core_rdata_s;

   assign in_range_s = ({1'b0, addr} < DEPTH_X);

   // Next-state, clear pointer, memory port muxing and pulse flags.
   always_comb begin
      state_d      = state_q;
      clr_ptr_d    = clr_ptr_q;
      read_valid_d = 1'b0;
      addr_err_d   = 1'b0;
      rd_seen_d    = rd_seen_q;
      mem_we_s     = 1'b0;
      mem_re_s     = 1'b0;
      mem_addr_s   = addr;
      mem_wdata_s  = write_data;

      case (state_q)
         ST_CLEAR: begin
            // Sweep write owns the port; user strobes are ignored.
            mem_we_s    = 1'b1;
            mem_addr_s  = clr_ptr_q;
            mem_wdata_s = INIT_VAL;
            if (clr_ptr_q == LAST_PTR) begin
               state_d   = ST_IDLE;
               clr_ptr_d = {ADDR_W{1'b0}};
            end else begin
               clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            end
         end

         ST_IDLE: begin
            if (clr_req) begin
               // Clear wins; any same-cycle access is dropped.
               state_d   = ST_CLEAR;
               clr_ptr_d = {ADDR_W{1'b0}};
            end else begin
               mem_we_s     = write_en & in_range_s;
               mem_re_s     = read_en & in_range_s;
               read_valid_d = read_en & in_range_s;
               addr_err_d   = (write_en | read_en) & ~in_range_s;
               if (read_en && in_range_s) begin
                  rd_seen_d = 1'b1;
               end else begin
                  rd_seen_d = rd_seen_q;
               end
            end
         end

         default: begin
            state_d   = ST_CLEAR;
            clr_ptr_d = {ADDR_W{1'b0}};
         end
      endcase
   end

   // Control registers; reset restarts a full sweep from word 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_CLEAR;
         clr_ptr_q    <= {ADDR_W{1'b0}};
         read_valid_q <= 1'b0;
         addr_err_q   <= 1'b0;
         rd_seen_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_ptr_q    <= clr_ptr_d;
         read_valid_q <= read_valid_d;
         addr_err_q   <= addr_err_d;
         rd_seen_q    <= rd_seen_d;
      end
   end

   ram_core #(
      .WIDTH         (WIDTH),
      .DEPTH         (DEPTH),
      .ADDR_W        (ADDR_W),
      .WRITE_THROUGH (WRITE_THROUGH)
   ) u_core (
      .clk     (clk),
      .we_i    (mem_we_s),
      .re_i    (mem_re_s),
      .addr_i  (mem_addr_s),
      .wdata_i (mem_wdata_s),
      .rdata_o (core_rdata_s)
   );

   assign ready      = (state_q == ST_IDLE);
   assign read_valid = read_valid_q;
   assign addr_err   = addr_err_q;
   assign read_data  = rd_seen_q ? core_rdata_s : {WIDTH{1'b0}};

endmodule : ram_clr
